// File: rtl/elevator_pkg.sv
// Shared types and floor-mask helpers for the elevator car controller.
package elevator_pkg;

    localparam int MAX_FLOORS = 32;

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN,
        ESTOP
    } state_e;

    typedef enum logic {
        UP = 1'b0,
        DN = 1'b1
    } dir_e;

    typedef logic [MAX_FLOORS-1:0] floor_mask_t;

    // Floors strictly above f; shifting past the top yields an empty mask.
    function automatic floor_mask_t above_mask(input int unsigned f);
        return floor_mask_t'('1) << (f + 32'd1);
    endfunction

    function automatic floor_mask_t below_mask(input int unsigned f);
        return (floor_mask_t'(1) << f) - floor_mask_t'(1);
    endfunction

endpackage

// File: rtl/elevator_req_latch.sv
// Sticky request register plus above/below/here flags relative to the car floor.
module elevator_req_latch
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 5,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_FLOORS-1:0] hall_up_i,
    input  logic [NUM_FLOORS-1:0] hall_dn_i,
    input  logic [NUM_FLOORS-1:0] car_i,
    input  logic [FLOOR_W-1:0]    floor_i,
    input  logic                  clr_en_i,
    input  logic [FLOOR_W-1:0]    clr_floor_i,
    output logic [NUM_FLOORS-1:0] eff_req_o,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  above_o,
    output logic                  below_o,
    output logic                  here_o
);

    logic [NUM_FLOORS-1:0] pending_q;
    logic [NUM_FLOORS-1:0] pending_d;
    logic [NUM_FLOORS-1:0] clr_mask;
    floor_mask_t           eff_ext;

    assign eff_req_o = pending_q | hall_up_i | hall_dn_i | car_i;
    assign eff_ext   = floor_mask_t'(eff_req_o);

    assign above_o = |(eff_ext & above_mask(32'(floor_i)));
    assign below_o = |(eff_ext & below_mask(32'(floor_i)));
    assign here_o  = eff_req_o[floor_i];

    assign clr_mask  = clr_en_i ? ({{(NUM_FLOORS-1){1'b0}}, 1'b1} << clr_floor_i) : '0;
    assign pending_d = eff_req_o & ~clr_mask;
    assign pending_o = pending_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/elevator_ctrl_gen.sv
// SCAN-order elevator car controller: FSM, travel/dwell timer and floor index.
module elevator_ctrl_gen
    import elevator_pkg::*;
#(
    parameter int  NUM_FLOORS    = 5,
    parameter int  TRAVEL_CYCLES = 4,
    parameter int  DOOR_CYCLES   = 3,
    localparam int FLOOR_W       = $clog2(NUM_FLOORS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_FLOORS-1:0] i_req_hall_up,
    input  logic [NUM_FLOORS-1:0] i_req_hall_dn,
    input  logic [NUM_FLOORS-1:0] i_req_car,
    input  logic                  i_stop,
    output logic [FLOOR_W-1:0]    o_floor,
    output logic                  o_up,
    output logic                  o_down,
    output logic                  o_door,
    output logic [NUM_FLOORS-1:0] o_pending,
    output logic                  o_arrive
);

    localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

    state_e                state_q;
    dir_e                  last_dir_q;
    logic [FLOOR_W-1:0]    floor_q;
    logic [TW-1:0]         timer_q;
    logic                  arrive_q;

    logic [NUM_FLOORS-1:0] eff_req;
    logic                  above, below, here;
    logic                  move_last;
    logic [FLOOR_W-1:0]    next_floor;
    logic                  next_here;
    logic                  next_ahead;
    floor_mask_t           ahead_mask;
    logic                  clr_en;
    logic [FLOOR_W-1:0]    clr_floor;

    assign move_last  = ((state_q == MOVE_UP) || (state_q == MOVE_DOWN)) && (timer_q == TRAVEL_LAST);
    assign next_floor = (state_q == MOVE_DOWN) ? floor_q - 1'b1 : floor_q + 1'b1;
    assign next_here  = eff_req[next_floor];
    assign ahead_mask = (state_q == MOVE_DOWN) ? below_mask(32'(next_floor))
                                               : above_mask(32'(next_floor));
    assign next_ahead = |(floor_mask_t'(eff_req) & ahead_mask);

    // Clearing the car-floor bit when not entering the door is harmless: that bit is already 0.
    assign clr_en    = !i_stop && ((state_q == IDLE) || (state_q == DOOR_OPEN) || move_last);
    assign clr_floor = move_last ? next_floor : floor_q;

    elevator_req_latch #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_req_latch (
        .CLK         (CLK),
        .RST         (RST),
        .hall_up_i   (i_req_hall_up),
        .hall_dn_i   (i_req_hall_dn),
        .car_i       (i_req_car),
        .floor_i     (floor_q),
        .clr_en_i    (clr_en),
        .clr_floor_i (clr_floor),
        .eff_req_o   (eff_req),
        .pending_o   (o_pending),
        .above_o     (above),
        .below_o     (below),
        .here_o      (here)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            last_dir_q <= UP;
            floor_q    <= '0;
            timer_q    <= '0;
            arrive_q   <= 1'b0;
        end else begin
            arrive_q <= 1'b0;
            if (i_stop) begin
                state_q <= ESTOP;
                timer_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        timer_q <= '0;
                        if (here) begin
                            state_q <= DOOR_OPEN;
                        end else if (above && below) begin
                            state_q <= (last_dir_q == UP) ? MOVE_UP : MOVE_DOWN;
                        end else if (above) begin
                            state_q <= MOVE_UP;
                        end else if (below) begin
                            state_q <= MOVE_DOWN;
                        end
                    end
                    MOVE_UP, MOVE_DOWN: begin
                        if (move_last) begin
                            floor_q    <= next_floor;
                            timer_q    <= '0;
                            arrive_q   <= 1'b1;
                            last_dir_q <= (state_q == MOVE_UP) ? UP : DN;
                            if (next_here) begin
                                state_q <= DOOR_OPEN;
                            end else if (!next_ahead) begin
                                state_q <= IDLE;
                            end
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    DOOR_OPEN: begin
                        // A fresh call for this floor re-opens the full dwell window.
                        if (here) begin
                            timer_q <= '0;
                        end else if (timer_q == DOOR_LAST) begin
                            state_q <= IDLE;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    ESTOP: begin
                        state_q <= IDLE;
                        timer_q <= '0;
                    end
                    default: begin
                        state_q <= IDLE;
                        timer_q <= '0;
                    end
                endcase
            end
        end
    end

    assign o_floor  = floor_q;
    assign o_up     = (state_q == MOVE_UP);
    assign o_down   = (state_q == MOVE_DOWN);
    assign o_door   = (state_q == DOOR_OPEN);
    assign o_arrive = arrive_q;

endmodule
